arith_mix_checker: RTL and testbench

ARITH_MIX_CHECKER -- requirements
Module: arith_mix_checker

---
 rtl/arith_mix_checker.sv | 270 +++++++++++++++++++++++++++
 tb/tb_arith_mix_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/arith_mix_checker.sv
`default_nettype none
// ============================================================================
//  Module      : arith_mix_checker
//  Description : Recomputes the expected result of a combinational arithmetic
//                mixing datapath from its operands and compares it with the
//                result observed on that datapath. Only one 8x8 multiplier is
//                used; it is time-shared over eight cycles (one product per
//                cycle), then all terms are combined in a single cycle.
//
//  Ports
//    clk        : single clock, rising-edge active
//    rst        : asynchronous active-high reset
//    in_valid   : operand set and observed result are valid
//    in_ready   : block can accept a new operand set (IDLE only)
//    a,b,c,d,e  : 8-bit operands
//    sel        : 3-bit term selector (t1..t7, combined term)
//    obs_y      : 16-bit result observed from the datapath under check
//    out_valid  : check result available (held until out_ready)
//    out_ready  : consumer accepts the check result
//    exp_y      : 16-bit expected result
//    mismatch   : obs_y differs from exp_y
//    err_count  : saturating count of mismatches
//
//  Revision    : 1.0 - initial release
// ============================================================================
module arith_mix_checker #(
    parameter logic [15:0] MASK_00FF = 16'h00FF,
    parameter logic [7:0]  MASK_0F   = 8'h0F,
    parameter logic [15:0] MASK_F0F0 = 16'hF0F0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [7:0]  c,
    input  logic [7:0]  d,
    input  logic [7:0]  e,
    input  logic [2:0]  sel,
    input  logic [15:0] obs_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] exp_y,
    output logic        mismatch,
    output logic [7:0]  err_count
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int         N_PROD    = 8;
    localparam logic [2:0] LAST_PROD = 3'd7;
    localparam logic [7:0] ERR_MAX   = 8'hFF;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    // Captured operand set; only written on the accepting edge so input
    // activity while busy cannot disturb the check in progress.
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [7:0]  r_c;
    logic [7:0]  r_d;
    logic [7:0]  r_e;
    logic [2:0]  r_sel;
    logic [15:0] r_obs;

    // Product sequencer and partial-product storage.
    logic [2:0]  r_cnt;
    logic [15:0] r_prod [N_PROD];

    // Result registers.
    logic [15:0] r_exp_y;
    logic        r_mismatch;
    logic [7:0]  r_err_count;

    // ------------------------------------------------------------------------
    // 8-bit truncated intermediate sums
    // ------------------------------------------------------------------------
    logic [7:0]  w_bc;
    logic [7:0]  w_ab;
    logic [7:0]  w_de;
    logic [7:0]  w_ac;

    assign w_bc = r_b + r_c;
    assign w_ab = r_a + r_b;
    assign w_de = r_d + r_e;
    assign w_ac = r_a + r_c;

    // ------------------------------------------------------------------------
    // Shared multiplier: the product counter selects the operand pair.
    // Order: a*bc, a*b, a*c, de*ab, d*a, d*b, e*a, e*b
    // ------------------------------------------------------------------------
    logic [7:0]  w_mul_x;
    logic [7:0]  w_mul_y;
    logic [15:0] w_prod;

    always_comb begin
        w_mul_x = r_a;
        w_mul_y = w_bc;
        case (r_cnt)
            3'd0: begin w_mul_x = r_a;  w_mul_y = w_bc; end
            3'd1: begin w_mul_x = r_a;  w_mul_y = r_b;  end
            3'd2: begin w_mul_x = r_a;  w_mul_y = r_c;  end
            3'd3: begin w_mul_x = w_de; w_mul_y = w_ab; end
            3'd4: begin w_mul_x = r_d;  w_mul_y = r_a;  end
            3'd5: begin w_mul_x = r_d;  w_mul_y = r_b;  end
            3'd6: begin w_mul_x = r_e;  w_mul_y = r_a;  end
            3'd7: begin w_mul_x = r_e;  w_mul_y = r_b;  end
            default: begin w_mul_x = r_a; w_mul_y = w_bc; end
        endcase
    end

    // Full 16-bit product of two 8-bit operands; it never overflows.
    assign w_prod = {8'h00, w_mul_x} * {8'h00, w_mul_y};

    // ------------------------------------------------------------------------
    // Term formation (all arithmetic modulo 2^16)
    // ------------------------------------------------------------------------
    logic [15:0] w_t1;
    logic [15:0] w_t2;
    logic [15:0] w_t3;
    logic [15:0] w_t4;
    logic [15:0] w_t5;
    logic [15:0] w_t6;
    logic [15:0] w_t7;
    logic [15:0] w_t8;
    logic [15:0] w_ac_mask;
    logic [15:0] w_exp;
    logic        w_mismatch;

    assign w_t1 = r_prod[0];
    assign w_t2 = r_prod[1] + r_prod[2];
    assign w_t3 = r_prod[3];
    assign w_t4 = r_prod[4] + r_prod[5] + r_prod[6] + r_prod[7];
    assign w_t5 = (w_t1 + w_t4) ^ (w_t3 & MASK_00FF);
    assign w_t6 = ((w_t2 << 1) + w_t5) ^ (w_t3 >> 1);

    // The mask restricts this multiplier to a 4-bit right operand by default.
    assign w_ac_mask = {8'h00, w_ac} & {8'h00, MASK_0F};
    assign w_t7 = (w_t6 + (w_t1 ^ w_t2)) * w_ac_mask;
    assign w_t8 = (w_t1 + w_t2 + w_t3) ^ (w_t4 & MASK_F0F0);

    always_comb begin
        w_exp = w_t1;
        case (r_sel)
            3'd0: w_exp = w_t1;
            3'd1: w_exp = w_t2;
            3'd2: w_exp = w_t3;
            3'd3: w_exp = w_t4;
            3'd4: w_exp = w_t5;
            3'd5: w_exp = w_t6;
            3'd6: w_exp = w_t7;
            3'd7: w_exp = w_t8;
            default: w_exp = w_t1;
        endcase
    end

    assign w_mismatch = (w_exp != r_obs);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == LAST_PROD) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_e         <= '0;
            r_sel       <= '0;
            r_obs       <= '0;
            r_cnt       <= '0;
            r_exp_y     <= '0;
            r_mismatch  <= 1'b0;
            r_err_count <= '0;
            for (int i = 0; i < N_PROD; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_c   <= c;
                        r_d   <= d;
                        r_e   <= e;
                        r_sel <= sel;
                        r_obs <= obs_y;
                        r_cnt <= '0;
                    end
                end
                S_CALC: begin
                    r_prod[r_cnt] <= w_prod;
                    // Wraps back to 0 after the last product.
                    r_cnt         <= r_cnt + 3'd1;
                end
                S_FIN: begin
                    r_exp_y    <= w_exp;
                    r_mismatch <= w_mismatch;
                    if (w_mismatch && (r_err_count != ERR_MAX)) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                end
                default: begin
                    // DONE: outputs held until the consumer takes them.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign exp_y     = r_exp_y;
    assign mismatch  = r_mismatch;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_arith_mix_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arith_mix_checker
//  Description : Scoreboard bench for arith_mix_checker. The stimulus thread
//                pushes hand-computed expected responses; a monitor pops and
//                compares whenever a result is handed off.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_mix_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [7:0]  d;
    logic [7:0]  e;
    logic [2:0]  sel;
    logic [15:0] obs_y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] exp_y;
    logic        mismatch;
    logic [7:0]  err_count;

    arith_mix_checker dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .sel       (sel),
        .obs_y     (obs_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp_y     (exp_y),
        .mismatch  (mismatch),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] y;
        logic        mm;
        logic [7:0]  err;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks  = 0;
    int         n_pass    = 0;
    logic [7:0] model_err = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: compares at each hand-off (sampled on the falling edge)
    // ------------------------------------------------------------------------
    initial begin : p_monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_result: actual out_valid=1 required no pending result");
                end else begin
                    x = sb_q.pop_front();
                    check("exp_y", {16'h0, exp_y}, {16'h0, x.y});
                    check("mismatch", {31'h0, mismatch}, {31'h0, x.mm});
                    check("err_count", {24'h0, err_count}, {24'h0, x.err});
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------------
    task automatic wait_ready();
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("in_ready_wait", {31'h0, in_ready}, 32'd1);
    endtask

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic,
                         input logic [7:0] id, input logic [7:0] ie, input logic [2:0] isel,
                         input logic [15:0] iobs, input logic [15:0] ey, input logic emm);
        int   lat;
        exp_t x;
        wait_ready();
        a = ia; b = ib; c = ic; d = id; e = ie; sel = isel; obs_y = iobs;
        in_valid = 1'b1;
        @(posedge clk); #1;
        if (emm && model_err != 8'hFF) model_err = model_err + 8'd1;
        x.y = ey; x.mm = emm; x.err = model_err;
        sb_q.push_back(x);
        // Scramble inputs and keep in_valid asserted while busy: must be ignored.
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            d = 8'($urandom); e = 8'($urandom); sel = 3'($urandom);
            obs_y = 16'($urandom);
            in_valid = 1'b1;
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        in_valid = 1'b0;
        check("latency", lat, 32'd9);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin : p_stim
        logic any_valid;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; d = '0; e = '0; sel = '0; obs_y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_exp_y", {16'h0, exp_y}, 32'd0);
        check("rst_mismatch", {31'h0, mismatch}, 32'd0);
        check("rst_err_count", {24'h0, err_count}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'd1);

        // Basic vectors: a=1,b=2,c=3,d=4,e=5
        issue(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 3'd0, 16'h0005, 16'h0005, 1'b0);
        issue(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 3'd1, 16'h0005, 16'h0005, 1'b0);
        issue(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 3'd2, 16'h001B, 16'h001B, 1'b0);
        issue(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 3'd3, 16'h001B, 16'h001B, 1'b0);
        issue(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 3'd4, 16'h003B, 16'h003B, 1'b0);
        issue(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 3'd5, 16'h0048, 16'h0048, 1'b0);
        issue(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 3'd6, 16'h0120, 16'h0120, 1'b0);
        issue(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 3'd7, 16'h0000, 16'h0035, 1'b1);

        // Truncation of the 8-bit intermediate sums
        issue(8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 3'd0, 16'h0000, 16'h0000, 1'b0);
        issue(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 3'd2, 16'hFC04, 16'hFC04, 1'b0);
        issue(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 3'd0, 16'h1234, 16'hFD02, 1'b1);

        // Backpressure: result held 20 cycles, new requests ignored
        wait_ready();
        out_ready = 1'b0;
        issue(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 3'd6, 16'h0120, 16'h0120, 1'b0);
        for (int k = 0; k < 20; k++) begin
            a = 8'($urandom); b = 8'($urandom); sel = 3'($urandom);
            in_valid = k[0];
            @(posedge clk); #1;
            check("bp_out_valid", {31'h0, out_valid}, 32'd1);
            check("bp_exp_y", {16'h0, exp_y}, 32'h0120);
            check("bp_in_ready", {31'h0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", {31'h0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'h0, in_ready}, 32'd1);

        // Saturation of the mismatch counter
        for (int n = 0; n < 260; n++) begin
            issue(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 3'd7, 16'h0000, 16'h0035, 1'b1);
        end
        check("sat_err_count", {24'h0, err_count}, 32'd255);

        // Reset during CALC aborts the check
        wait_ready();
        a = 8'd1; b = 8'd2; c = 8'd3; d = 8'd4; e = 8'd5; sel = 3'd0; obs_y = 16'h0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        model_err = 8'd0;
        #1;
        check("abort_out_valid", {31'h0, out_valid}, 32'd0);
        check("abort_err_count", {24'h0, err_count}, 32'd0);
        check("abort_exp_y", {16'h0, exp_y}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        any_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (out_valid) any_valid = 1'b1;
        end
        check("abort_no_out_valid", {31'h0, any_valid}, 32'd0);
        check("abort_in_ready", {31'h0, in_ready}, 32'd1);

        // Normal operation resumes with a cleared counter
        issue(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 3'd7, 16'h0000, 16'h0035, 1'b1);
        issue(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 3'd0, 16'h0005, 16'h0005, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : p_timeout
        #2000000;
        $display("FAIL timeout: actual simulation still running required finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
